// File: rtl/sema_mailbox.sv
// sema_mailbox: two independent 1-bit show-ahead FIFOs between the bit unit and the byte unit,
// with occupancy counts and shared sticky overflow/underflow flags.
module sema_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          din,
    input  logic          pop_req,
    output logic          valid,
    output logic          head,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ov_evt
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             push_ok;
    // A push into a full FIFO is only accepted when a pop frees the slot on the same edge.
    always_comb begin
        valid   = count != '0;
        full    = count == CW'(DEPTH);
        pop     = valid & pop_req;
        push_ok = push & (~full | pop);
        head    = valid ? mem[rd_ptr] : 1'b0;
        ov_evt  = push & full & ~pop;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end
endmodule

module sema_mailbox #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          byte_valid_o,
    output logic          byte_data_o,
    input  logic          byte_ready_i,
    output logic          byte_is_empty_o,
    input  logic          byte_write_i,
    input  logic          byte_data_i,
    input  logic          bit_write_i,
    input  logic          bit_data_i,
    output logic          bit_full_o,
    output logic          bit_valid_o,
    output logic          bit_data_o,
    input  logic          bit_read_i,
    output logic [CW-1:0] up_count_o,
    output logic [CW-1:0] dn_count_o,
    input  logic          clear_flags_i,
    output logic          overflow_o,
    output logic          underflow_o
);
    logic up_ov;
    logic dn_ov;
    logic dn_full;
    logic uf_evt;
    sema_fifo #(.DEPTH(DEPTH), .CW(CW)) u_up (
        .clk     (clk),
        .rstn    (rstn),
        .push    (bit_write_i),
        .din     (bit_data_i),
        .pop_req (byte_ready_i),
        .valid   (byte_valid_o),
        .head    (byte_data_o),
        .full    (bit_full_o),
        .count   (up_count_o),
        .ov_evt  (up_ov)
    );
    sema_fifo #(.DEPTH(DEPTH), .CW(CW)) u_dn (
        .clk     (clk),
        .rstn    (rstn),
        .push    (byte_write_i),
        .din     (byte_data_i),
        .pop_req (bit_read_i),
        .valid   (bit_valid_o),
        .head    (bit_data_o),
        .full    (dn_full),
        .count   (dn_count_o),
        .ov_evt  (dn_ov)
    );
    // The byte unit holds ready as a level, so only the bit unit's read can underflow.
    always_comb begin
        byte_is_empty_o = ~dn_full;
        uf_evt          = bit_read_i & ~bit_valid_o;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= up_ov | dn_ov | (overflow_o & ~clear_flags_i);
            underflow_o <= uf_evt | (underflow_o & ~clear_flags_i);
        end
    end
endmodule

// File: doc/sema_mailbox.md
Name: sema_mailbox

Overview:
- Semaphore memory between the bit unit and byte_unit_top: two independent single-bit-wide FIFOs.
- Upstream FIFO carries bit unit → byte unit and drives the byte unit's sema_valid_i/sema_data_i; it consumes the byte unit's sema_ready_o.
- Downstream FIFO carries byte unit → bit unit; it accepts the byte unit's sema_write_o/sema_data_o and returns sema_is_empty_i.
- Provides occupancy counts and sticky overflow/underflow flags for debug.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- CW, $clog2(DEPTH)+1, width of the occupancy counters.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- byte_valid_o  output  1  upstream FIFO non-empty (to byte unit sema_valid_i).
- byte_data_o  output  1  upstream FIFO head bit (to byte unit sema_data_i).
- byte_ready_i  input  1  byte unit pop request (from sema_ready_o).
- byte_is_empty_o  output  1  downstream FIFO has ≥1 free slot (to byte unit sema_is_empty_i).
- byte_write_i  input  1  byte unit push strobe (from sema_write_o).
- byte_data_i  input  1  byte unit push data (from sema_data_o).
- bit_write_i  input  1  bit unit push strobe, upstream FIFO.
- bit_data_i  input  1  bit unit push data.
- bit_full_o  output  1  upstream FIFO full.
- bit_valid_o  output  1  downstream FIFO non-empty.
- bit_data_o  output  1  downstream FIFO head bit.
- bit_read_i  input  1  bit unit pop strobe, downstream FIFO.
- up_count_o  output  CW  upstream occupancy, 0..DEPTH.
- dn_count_o  output  CW  downstream occupancy, 0..DEPTH.
- clear_flags_i  input  1  synchronous clear of the sticky flags.
- overflow_o  output  1  sticky: a push was dropped.
- underflow_o  output  1  sticky: a pop was attempted on an empty FIFO.

Behaviour:
- Reset (rstn low, asynchronous):
  - All pointers and counts go to 0; storage is cleared.
  - byte_valid_o=0, byte_data_o=0, bit_valid_o=0, bit_data_o=0.
  - bit_full_o=0, byte_is_empty_o=1, overflow_o=0, underflow_o=0.
- Reset mid-operation: all queued entries are discarded; no partial state survives.
- Both FIFOs are identical show-ahead FIFOs. Each has a write pointer and a read pointer of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a registered count.
- Push:
  - Upstream push is bit_write_i; downstream push is byte_write_i.
  - Data is written at the write pointer on the clk edge; the pointer then increments.
  - Push-to-visible latency is 1 cycle: valid and head data update the cycle after the push edge.
- Pop:
  - Upstream pop is byte_valid_o & byte_ready_i; downstream pop is bit_valid_o & bit_read_i.
  - The read pointer increments on the clk edge.
  - Head data is storage[rd_ptr], read from registered storage with no bypass.
  - Head data is driven to 0 whenever the FIFO is empty.
- Status outputs:
  - valid = (count != 0).
  - bit_full_o = (up_count == DEPTH).
  - byte_is_empty_o = (dn_count != DEPTH), i.e. a free slot exists.
  - All are derived from registered state, with no combinational path from any input.
- byte_ready_i held high drains one entry per cycle. The byte unit asserting byte_write_i while byte_is_empty_o=0 counts as an overflow.
- Simultaneous push and pop on a non-empty FIFO: both occur and the count is unchanged.
- Simultaneous push and pop on a full FIFO: both accepted, no overflow, count stays DEPTH.
- Push and pop request on an empty FIFO:
  - The push is accepted.
  - The pop is ignored (valid=0) and sets underflow_o.
  - Count becomes 1.
- Push when full without a simultaneous pop:
  - Data is dropped; pointers and count are unchanged.
  - overflow_o is set.
- Pop request with valid=0: no pointer change; underflow_o is set. On the upstream side, byte_ready_i while byte_valid_o=0 is not an underflow. The byte unit holds ready as a status level, so only bit_read_i can underflow.
- Flags:
  - Flags are sticky until clear_flags_i.
  - If an event and clear_flags_i occur in the same cycle, the event wins and the flag stays 1.
  - Both FIFOs share the two flags.
- Bit order is strictly FIFO; the two directions never interact.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with random inputs → all outputs equal their reset values; byte_is_empty_o=1, up_count_o=0.
- Upstream ordering: bit unit pushes 1,0,1,1 on consecutive cycles with byte_ready_i=0 → bit_full_o=1 and up_count_o=4. Then byte_ready_i=1 → byte_data_o shows 1,0,1,1 on successive cycles, then byte_valid_o=0 and data=0.
- Overflow: with the upstream FIFO full, bit_write_i with data 0 and no pop → overflow_o=1, up_count_o stays 4, and the drained sequence is unchanged. Then clear_flags_i → overflow_o=0 next cycle.
- Full simultaneous: upstream full, push 0 and pop in the same cycle → up_count_o=4, overflow_o=0. The last drained bit is 0 (wrap-around verified over 3 full cycles of the pointers).
- Downstream/underflow: bit_read_i on an empty FIFO → underflow_o=1. byte_write_i with data 1 in the same cycle as bit_read_i on empty → dn_count_o=1, bit_valid_o=1 next cycle, bit_data_o=1.
- Async reset mid-stream: assert rstn low between clock edges with 3 entries queued → outputs reset immediately without waiting for clk; after release, byte_valid_o=0 and counts are 0.
